// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states, mouse packet bit positions and
// packet length, plus the clamp helper used for cursor arithmetic.
package ps2_pkg;

   typedef enum logic [1:0] {
      FR_IDLE,
      FR_DATA,
      FR_PARITY,
      FR_STOP
   } frame_state_e;

   localparam int LEFT    = 0;
   localparam int RIGHT   = 1;
   localparam int SYNC    = 3;
   localparam int XSIGN   = 4;
   localparam int YSIGN   = 5;
   localparam int XOVF    = 6;
   localparam int YOVF    = 7;
   localparam int PKT_LEN = 3;

   typedef struct packed {
      logic yovf;
      logic xovf;
      logic ysign;
      logic xsign;
      logic right;
      logic left;
   } pkt_hdr_t;

   function automatic logic [11:0] clamp_pos(input logic signed [13:0] v, input int max_v);
      if (v < 14'sd0)
         clamp_pos = '0;
      else if (v > $signed(14'(max_v)))
         clamp_pos = 12'(max_v);
      else
         clamp_pos = 12'(v);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: sync + falling-edge detect, 11-bit frame FSM, idle timeout.
// Latency: byte_valid/byte_err pulse combinationally in the cycle the stop bit is sampled; no backpressure.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT = 65000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       byte_err_o,
   output logic       timeout_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   logic          clk_s1_q, clk_s2_q, clk_s3_q;
   logic          data_s1_q, data_s2_q;
   logic          fall;
   logic [TW-1:0] to_cnt_q;

   frame_state_e  state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;

   // Synchroniser flops reset to 1 so a reset never fabricates a falling edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         clk_s3_q  <= 1'b1;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_clk_i;
         clk_s2_q  <= clk_s1_q;
         clk_s3_q  <= clk_s2_q;
         data_s1_q <= ps2_data_i;
         data_s2_q <= data_s1_q;
      end
   end

   assign fall = clk_s3_q & ~clk_s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         to_cnt_q <= '0;
      else if (fall)
         to_cnt_q <= '0;
      else if (to_cnt_q != TO_MAX)
         to_cnt_q <= to_cnt_q + 1'b1;
   end

   // Fires once per idle stretch; mutually exclusive with any sampling edge.
   assign timeout_o = !fall && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= FR_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_ok_q  <= par_ok_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_ok_d     = par_ok_q;
      byte_valid_o = 1'b0;
      byte_err_o   = 1'b0;
      if (timeout_o) begin
         state_d = FR_IDLE;
      end else if (fall) begin
         case (state_q)
            FR_IDLE: begin
               if (!data_s2_q) begin
                  state_d   = FR_DATA;
                  bit_cnt_d = '0;
               end
            end
            FR_DATA: begin
               shift_d   = {data_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_d = FR_PARITY;
            end
            FR_PARITY: begin
               par_ok_d = (^shift_q) ^ data_s2_q;
               state_d  = FR_STOP;
            end
            FR_STOP: begin
               state_d = FR_IDLE;
               if (data_s2_q && par_ok_q)
                  byte_valid_o = 1'b1;
               else
                  byte_err_o = 1'b1;
            end
            default: state_d = FR_IDLE;
         endcase
      end
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/mouse_ps2_rx.sv
// PS/2 mouse receiver: assembles 3-byte packets into a clamped cursor position and button state.
// Latency: outputs update 1 clk after b2's stop bit is sampled; no backpressure (mouse cannot be stalled).
module mouse_ps2_rx
   import ps2_pkg::*;
#(
   parameter int X_MAX   = 1023,
   parameter int Y_MAX   = 767,
   parameter int X_INIT  = 512,
   parameter int Y_INIT  = 384,
   parameter int TIMEOUT = 65000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        mouse_left,
   output logic        mouse_right,
   output logic        new_event,
   output logic        err
);

   localparam logic [1:0] IDX_LAST = 2'(PKT_LEN - 1);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err, rx_timeout;

   logic [1:0]         idx_q, idx_d;
   pkt_hdr_t           hdr_q, hdr_d;
   logic [7:0]         b1_q, b1_d;
   logic [11:0]        xpos_q, xpos_d, ypos_q, ypos_d;
   logic               left_q, left_d, right_q, right_d;
   logic               evt_q, evt_d, err_q, err_d;
   logic signed [13:0] dx, dy, xsum, ysum;

   ps2_rx_frame #(
      .TIMEOUT(TIMEOUT)
   ) u_frame (
      .clk_i       (clk),
      .rst_i       (rst),
      .ps2_clk_i   (ps2_clk),
      .ps2_data_i  (ps2_data),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .byte_err_o  (rx_err),
      .timeout_o   (rx_timeout)
   );

   // 9-bit deltas widened to 14 bits so the sum can go negative or past the max without wrapping.
   assign dx   = $signed({{5{hdr_q.xsign}}, hdr_q.xsign, b1_q});
   assign dy   = $signed({{5{hdr_q.ysign}}, hdr_q.ysign, rx_byte});
   assign xsum = $signed({2'b00, xpos_q}) + dx;
   assign ysum = $signed({2'b00, ypos_q}) - dy;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         hdr_q   <= '0;
         b1_q    <= '0;
         xpos_q  <= 12'(X_INIT);
         ypos_q  <= 12'(Y_INIT);
         left_q  <= 1'b0;
         right_q <= 1'b0;
         evt_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         hdr_q   <= hdr_d;
         b1_q    <= b1_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         left_q  <= left_d;
         right_q <= right_d;
         evt_q   <= evt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      idx_d   = idx_q;
      hdr_d   = hdr_q;
      b1_d    = b1_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      left_d  = left_q;
      right_d = right_q;
      evt_d   = 1'b0;
      err_d   = rx_err;
      if (rx_err || rx_timeout) begin
         idx_d = '0;
      end else if (rx_valid) begin
         if (idx_q == 2'd0) begin
            // A header without the always-one bit means we are out of step; stay at 0 to resync.
            if (rx_byte[SYNC]) begin
               hdr_d.yovf  = rx_byte[YOVF];
               hdr_d.xovf  = rx_byte[XOVF];
               hdr_d.ysign = rx_byte[YSIGN];
               hdr_d.xsign = rx_byte[XSIGN];
               hdr_d.right = rx_byte[RIGHT];
               hdr_d.left  = rx_byte[LEFT];
               idx_d       = 2'd1;
            end else begin
               err_d = 1'b1;
            end
         end else if (idx_q != IDX_LAST) begin
            b1_d  = rx_byte;
            idx_d = idx_q + 2'd1;
         end else begin
            idx_d   = '0;
            evt_d   = 1'b1;
            left_d  = hdr_q.left;
            right_d = hdr_q.right;
            if (!hdr_q.xovf)
               xpos_d = clamp_pos(xsum, X_MAX);
            if (!hdr_q.yovf)
               ypos_d = clamp_pos(ysum, Y_MAX);
         end
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign mouse_left  = left_q;
   assign mouse_right = right_q;
   assign new_event   = evt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mouse_ps2_rx.sv
// Bench for mouse_ps2_rx: table of packets plus hand-written corner sequences,
// expected cursor states queued on send and compared when new_event fires.
module tb_mouse_ps2_rx;

   localparam int TO   = 400;
   localparam int HALF = 8;
   localparam int NV   = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_data;
   logic [11:0] xpos, ypos;
   logic        mouse_left, mouse_right, new_event, err;

   always #5 clk = ~clk;

   mouse_ps2_rx #(
      .TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .xpos       (xpos),
      .ypos       (ypos),
      .mouse_left (mouse_left),
      .mouse_right(mouse_right),
      .new_event  (new_event),
      .err        (err)
   );

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        l;
      logic        r;
   } exp_t;

   typedef struct {
      logic [7:0] b [5];
      int         n;
      int         bad_idx;
      exp_t       e;
      int         errs;
   } vec_t;

   vec_t vt [NV];
   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   err_seen = 0;
   int   cur_vec  = -1;
   logic ne_prev  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic d);
      ps2_data = d;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic ps2_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic p;
      p = ~^b;
      if (bad_par) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(bad_stop ? 1'b0 : 1'b1);
      ps2_data = 1'b1;
      wait_clk(2 * HALF);
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      ps2_byte(b0, 1'b0, 1'b0);
      ps2_byte(b1, 1'b0, 1'b0);
      ps2_byte(b2, 1'b0, 1'b0);
   endtask

   task automatic set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                          input int n, input int bad, input int ex, input int ey,
                          input logic l, input logic r, input int errs);
      vt[i].b[0]  = b0;
      vt[i].b[1]  = b1;
      vt[i].b[2]  = b2;
      vt[i].b[3]  = b3;
      vt[i].b[4]  = b4;
      vt[i].n       = n;
      vt[i].bad_idx = bad;
      vt[i].e.x     = 12'(ex);
      vt[i].e.y     = 12'(ey);
      vt[i].e.l     = l;
      vt[i].e.r     = r;
      vt[i].errs    = errs;
   endtask

   // After a packet: event consumed, error count as expected, outputs holding the new state.
   task automatic post_checks(input string tag, input int err_base, input int errs, input exp_t e);
      wait_clk(10);
      check($sformatf("%s_evt_consumed", tag), sb_q.size(), 0);
      check($sformatf("%s_err_pulses", tag), err_seen - err_base, errs);
      check($sformatf("%s_hold_state", tag), {xpos, ypos, mouse_left, mouse_right}, e);
      sb_q.delete();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (err) err_seen++;
      if (new_event) begin
         check($sformatf("v%0d_evt_single", cur_vec), ne_prev, 0);
         check($sformatf("v%0d_evt_expected", cur_vec), sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_xpos", cur_vec), xpos, e.x);
            check($sformatf("v%0d_ypos", cur_vec), ypos, e.y);
            check($sformatf("v%0d_left", cur_vec), mouse_left, e.l);
            check($sformatf("v%0d_right", cur_vec), mouse_right, e.r);
         end
      end
      ne_prev = new_event;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int   e0;
      exp_t eh;

      // Chained packets: each expected state follows from the previous one.
      set_vec( 0, 8'h09, 8'h10, 8'h05, 8'h00, 8'h00, 3, -1,  528, 379, 1, 0, 0);
      set_vec( 1, 8'h00, 8'h0A, 8'h01, 8'h01, 8'h00, 4, -1,  529, 378, 0, 1, 1);
      set_vec( 2, 8'h09, 8'h33, 8'h09, 8'h10, 8'h05, 5,  1,  545, 373, 1, 0, 1);
      set_vec( 3, 8'h08, 8'h7F, 8'h00, 8'h00, 8'h00, 3, -1,  672, 373, 0, 0, 0);
      set_vec( 4, 8'h08, 8'h7F, 8'h00, 8'h00, 8'h00, 3, -1,  799, 373, 0, 0, 0);
      set_vec( 5, 8'h08, 8'h7F, 8'h00, 8'h00, 8'h00, 3, -1,  926, 373, 0, 0, 0);
      set_vec( 6, 8'h08, 8'h5E, 8'h00, 8'h00, 8'h00, 3, -1, 1020, 373, 0, 0, 0);
      set_vec( 7, 8'h08, 8'h0A, 8'h00, 8'h00, 8'h00, 3, -1, 1023, 373, 0, 0, 0);
      set_vec( 8, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 3, -1,  767, 373, 0, 0, 0);
      set_vec( 9, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 3, -1,  511, 373, 0, 0, 0);
      set_vec(10, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 3, -1,  255, 373, 0, 0, 0);
      set_vec(11, 8'h18, 8'h0B, 8'h00, 8'h00, 8'h00, 3, -1,   10, 373, 0, 0, 0);
      set_vec(12, 8'h18, 8'hF0, 8'h00, 8'h00, 8'h00, 3, -1,    0, 373, 0, 0, 0);
      set_vec(13, 8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 3, -1,    0, 629, 0, 0, 0);
      set_vec(14, 8'h28, 8'h00, 8'h00, 8'h00, 8'h00, 3, -1,    0, 767, 0, 0, 0);
      set_vec(15, 8'h49, 8'h20, 8'h03, 8'h00, 8'h00, 3, -1,    0, 764, 1, 0, 0);
      set_vec(16, 8'h88, 8'h05, 8'h05, 8'h00, 8'h00, 3, -1,    5, 764, 0, 0, 0);
      set_vec(17, 8'h08, 8'h00, 8'hFF, 8'h00, 8'h00, 3, -1,    5, 509, 0, 0, 0);
      set_vec(18, 8'h08, 8'h00, 8'hFF, 8'h00, 8'h00, 3, -1,    5, 254, 0, 0, 0);
      set_vec(19, 8'h08, 8'h00, 8'hFF, 8'h00, 8'h00, 3, -1,    5,   0, 0, 0, 0);

      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(1);
      check("rst_xpos", xpos, 512);
      check("rst_ypos", ypos, 384);
      check("rst_buttons", {mouse_left, mouse_right}, 0);
      check("rst_new_event", new_event, 0);
      check("rst_err", err, 0);

      for (int i = 0; i < NV; i++) begin
         cur_vec = i;
         e0 = err_seen;
         sb_q.push_back(vt[i].e);
         for (int k = 0; k < vt[i].n; k++)
            ps2_byte(vt[i].b[k], k == vt[i].bad_idx, 1'b0);
         post_checks($sformatf("v%0d", i), e0, vt[i].errs, vt[i].e);
      end

      // Timeout abandons a half-sent packet without an error pulse.
      cur_vec = 100;
      e0 = err_seen;
      ps2_byte(8'h08, 1'b0, 1'b0);
      ps2_byte(8'h40, 1'b0, 1'b0);
      wait_clk(2 * TO);
      eh = '{x: 12'd9, y: 12'd0, l: 1'b0, r: 1'b0};
      sb_q.push_back(eh);
      send_pkt(8'h08, 8'h04, 8'h00);
      post_checks("timeout", e0, 0, eh);

      // Stop bit of 0 rejects the byte.
      cur_vec = 101;
      e0 = err_seen;
      ps2_byte(8'h08, 1'b0, 1'b1);
      eh = '{x: 12'd10, y: 12'd0, l: 1'b0, r: 1'b0};
      sb_q.push_back(eh);
      send_pkt(8'h08, 8'h01, 8'h00);
      post_checks("bad_stop", e0, 1, eh);

      // A lone clock pulse with data high in idle is not a start bit.
      cur_vec = 102;
      e0 = err_seen;
      ps2_bit(1'b1);
      wait_clk(2 * HALF);
      eh = '{x: 12'd12, y: 12'd0, l: 1'b0, r: 1'b1};
      sb_q.push_back(eh);
      send_pkt(8'h0A, 8'h02, 8'h00);
      post_checks("start_one", e0, 0, eh);

      // Reset in the middle of b2 drops the partial packet.
      cur_vec = 103;
      ps2_byte(8'h09, 1'b0, 1'b0);
      ps2_byte(8'h10, 1'b0, 1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      ps2_data = 1'b1;
      wait_clk(2);
      check("midrst_state", {xpos, ypos, mouse_left, mouse_right}, {12'd512, 12'd384, 2'b00});
      e0 = err_seen;
      eh = '{x: 12'd514, y: 12'd384, l: 1'b0, r: 1'b0};
      sb_q.push_back(eh);
      send_pkt(8'h08, 8'h02, 8'h00);
      post_checks("midrst", e0, 0, eh);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
